// File: rtl/output_packer_pkg.sv
// output_packer_pkg
//   Shared constants, types and helpers for the output_packer slice.
//   Contents:
//     DEF_*       default configuration of the packer
//     cnt_w()     counter width for a modulo-n counter (never below 1)
//     beat_t      one packed output beat in the default configuration
//     sat_clips() unsigned clip test, only when OUTPUT_PACKER_SATURATE_EN is defined
package output_packer_pkg;

   localparam int DEF_DATA_WIDTH = 18;
   localparam int DEF_OUT_WIDTH  = 16;
   localparam int DEF_PACK       = 4;
   localparam int DEF_LINE_LEN   = 64;
   localparam int DEF_NUM_LINES  = 64;

   // A modulo-1 counter still needs one bit so the port/flop is legal.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_LANE_W = cnt_w(DEF_PACK);

   typedef struct packed {
      logic [DEF_OUT_WIDTH*DEF_PACK-1:0] data;
      logic [DEF_PACK-1:0]               keep;
      logic                              last;
      logic                              user;
   } beat_t;

`ifdef OUTPUT_PACKER_SATURATE_EN
   // True when the unsigned sample does not fit in ow bits.
   // Samples are zero-extended to 64 bits by the caller.
   function automatic logic sat_clips(input logic [63:0] d, input int ow);
      return (d >> ow) != 64'd0;
   endfunction
`endif

endpackage

// File: rtl/packer_lane_assembler.sv
// packer_lane_assembler
//   Collects narrowed samples into PACK lanes and presents the beat that
//   would result if the current sample completed it.
//   Ports:
//     clk, rstn   clock, synchronous active-low reset
//     push        a sample is accepted this cycle
//     done        the accepted sample completes the beat (clears the lanes)
//     lane_in     narrowed sample
//     lane_cnt    index of the lane the next sample lands in
//     lane_full   lane_cnt == PACK-1
//     beat_data   stored lanes with lane_in merged at lane_cnt, upper lanes 0
//     beat_keep   lanes 0..lane_cnt set
module packer_lane_assembler
   import output_packer_pkg::*;
#(
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int PACK      = DEF_PACK,
   localparam int LANE_W   = cnt_w(PACK)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      push,
   input  logic                      done,
   input  logic [OUT_WIDTH-1:0]      lane_in,
   output logic [LANE_W-1:0]         lane_cnt,
   output logic                      lane_full,
   output logic [OUT_WIDTH*PACK-1:0] beat_data,
   output logic [PACK-1:0]           beat_keep
);

   logic [OUT_WIDTH*PACK-1:0] lanes_q, lanes_d;
   logic [LANE_W-1:0]         lane_cnt_q, lane_cnt_d;

   // Lanes at or above lane_cnt are always zero, so the merged beat is the
   // stored lanes with the incoming sample dropped into its slot.
   always_comb begin
      beat_data = lanes_q;
      beat_keep = '0;
      for (int i = 0; i < PACK; i++) begin
         if (i == int'(lane_cnt_q)) beat_data[i*OUT_WIDTH +: OUT_WIDTH] = lane_in;
         beat_keep[i] = (i <= int'(lane_cnt_q));
      end

      lanes_d    = lanes_q;
      lane_cnt_d = lane_cnt_q;
      if (push && done) begin
         lanes_d    = '0;
         lane_cnt_d = '0;
      end else if (push) begin
         lanes_d    = beat_data;
         lane_cnt_d = lane_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         lanes_q    <= '0;
         lane_cnt_q <= '0;
      end else begin
         lanes_q    <= lanes_d;
         lane_cnt_q <= lane_cnt_d;
      end
   end

   assign lane_cnt  = lane_cnt_q;
   assign lane_full = (int'(lane_cnt_q) == PACK - 1);

endmodule

// File: rtl/output_packer.sv
// output_packer
//   Narrows the crossbar result stream to OUT_WIDTH, packs PACK samples per
//   beat and frames beats per line (tlast) and per frame (tuser).
//   Optional macro OUTPUT_PACKER_SATURATE_EN: clip instead of truncate and
//   expose a sticky sat_flag output.
//   Ports:
//     clk, rstn       clock, synchronous active-low reset
//     s_axis_*        sample input (tvalid/tdata/tready)
//     m_axis_*        packed beat output (tvalid/tdata/tkeep/tlast/tuser/tready)
//     frame_done      pulse the cycle after the last beat of a frame is taken
//     sat_flag        (macro only) some sample has been clipped since reset
module output_packer
   import output_packer_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
   parameter int PACK       = DEF_PACK,
   parameter int LINE_LEN   = DEF_LINE_LEN,
   parameter int NUM_LINES  = DEF_NUM_LINES
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   output logic                      s_axis_tready,
   output logic                      m_axis_tvalid,
   output logic [OUT_WIDTH*PACK-1:0] m_axis_tdata,
   output logic [PACK-1:0]           m_axis_tkeep,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tuser,
   input  logic                      m_axis_tready,
   output logic                      frame_done
`ifdef OUTPUT_PACKER_SATURATE_EN
   ,
   output logic                      sat_flag
`endif
);

   localparam int SAMP_W = cnt_w(LINE_LEN);
   localparam int LINE_W = cnt_w(NUM_LINES);
   localparam int LANE_W = cnt_w(PACK);

   logic [SAMP_W-1:0]         samp_cnt_q, samp_cnt_d;
   logic [LINE_W-1:0]         line_cnt_q, line_cnt_d;
   logic                      m_valid_q, m_valid_d;
   logic [OUT_WIDTH*PACK-1:0] m_data_q, m_data_d;
   logic [PACK-1:0]           m_keep_q, m_keep_d;
   logic                      m_last_q, m_last_d;
   logic                      m_user_q, m_user_d;
   logic                      frame_end_q, frame_end_d;   // loaded beat closes the frame
   logic                      frame_done_q, frame_done_d;

   logic [LANE_W-1:0]         lane_cnt;
   logic                      lane_full;
   logic [OUT_WIDTH*PACK-1:0] beat_data;
   logic [PACK-1:0]           beat_keep;
   logic [OUT_WIDTH-1:0]      lane_val;
   logic                      line_end, completing, accept;

   // Completion is a function of the counters only, so tready never depends
   // on s_axis_tvalid or on the sample value.
   assign line_end      = (int'(samp_cnt_q) == LINE_LEN - 1);
   assign completing    = lane_full || line_end;
   assign s_axis_tready = !completing || !m_valid_q || m_axis_tready;
   assign accept        = rstn && s_axis_tvalid && s_axis_tready;

`ifdef OUTPUT_PACKER_SATURATE_EN
   logic clip;
   logic sat_q, sat_d;
   assign clip     = sat_clips(64'(s_axis_tdata), OUT_WIDTH);
   assign lane_val = clip ? '1 : s_axis_tdata[OUT_WIDTH-1:0];
   assign sat_d    = sat_q || (accept && clip);
   assign sat_flag = sat_q;

   always_ff @(posedge clk) begin
      if (!rstn) sat_q <= 1'b0;
      else       sat_q <= sat_d;
   end
`else
   assign lane_val = s_axis_tdata[OUT_WIDTH-1:0];
   // Bits above OUT_WIDTH are intentionally dropped by truncation.
   if (DATA_WIDTH > OUT_WIDTH) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^s_axis_tdata[DATA_WIDTH-1:OUT_WIDTH];
   end
`endif

   packer_lane_assembler #(
      .OUT_WIDTH (OUT_WIDTH),
      .PACK      (PACK)
   ) u_asm (
      .clk       (clk),
      .rstn      (rstn),
      .push      (accept),
      .done      (completing),
      .lane_in   (lane_val),
      .lane_cnt  (lane_cnt),
      .lane_full (lane_full),
      .beat_data (beat_data),
      .beat_keep (beat_keep)
   );

   always_comb begin
      samp_cnt_d   = samp_cnt_q;
      line_cnt_d   = line_cnt_q;
      m_valid_d    = m_valid_q && !m_axis_tready;
      m_data_d     = m_data_q;
      m_keep_d     = m_keep_q;
      m_last_d     = m_last_q;
      m_user_d     = m_user_q;
      frame_end_d  = frame_end_q;
      frame_done_d = m_valid_q && m_axis_tready && frame_end_q;

      if (accept) begin
         if (line_end) begin
            samp_cnt_d = '0;
            line_cnt_d = (int'(line_cnt_q) == NUM_LINES - 1) ? '0 : line_cnt_q + 1'b1;
         end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
         end

         if (completing) begin
            m_valid_d   = 1'b1;
            m_data_d    = beat_data;
            m_keep_d    = beat_keep;
            m_last_d    = line_end;
            // Beats never straddle a line, so the beat's first sample sits at
            // samp_cnt - lane_cnt on the current line.
            m_user_d    = (line_cnt_q == '0) && (int'(samp_cnt_q) == int'(lane_cnt));
            frame_end_d = line_end && (int'(line_cnt_q) == NUM_LINES - 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         samp_cnt_q   <= '0;
         line_cnt_q   <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_keep_q     <= '0;
         m_last_q     <= 1'b0;
         m_user_q     <= 1'b0;
         frame_end_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         samp_cnt_q   <= samp_cnt_d;
         line_cnt_q   <= line_cnt_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_keep_q     <= m_keep_d;
         m_last_q     <= m_last_d;
         m_user_q     <= m_user_d;
         frame_end_q  <= frame_end_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tuser  = m_user_q;
   assign frame_done    = frame_done_q;

endmodule
